// File: rtl/axis_width_conv_pkg.sv
// Shared definitions for the AXI-Stream width converters.
package axis_width_conv_pkg;

    // Width of the bit_count occupancy output of both converters.
    localparam int BIT_COUNT_W = 16;

    // Number of bits needed to hold a counter of values 0..depth-1 (at least 1).
    function automatic int cnt_width(input int depth);
        int w_v;
        w_v = 1;
        while ((1 << w_v) < depth) begin
            w_v = w_v + 1;
        end
        return w_v;
    endfunction

endpackage

// File: rtl/axis_width_conv_narrow_wide.sv
// Narrow-to-wide stream width converter.
// Collects R = N/M narrow words MSB-first into one wide word. A word that
// carries tfirst while a group is partially filled is held back; the partial
// group is flushed zero-padded in its LSBs and the held word then opens a new
// group. The output register is a single skid-free stage that can be reloaded
// on the same edge it is drained, so a held-high m_axis_tnext sustains one
// narrow word per cycle.
module axis_width_conv_narrow_wide
    import axis_width_conv_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [M-1:0]           s_axis_tdata,
    input  logic                   s_axis_tfirst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tnext,
    output logic [N-1:0]           m_axis_tdata,
    output logic                   m_axis_tfirst,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tnext,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    // Reject widths that cannot be packed evenly.
    if ((M < 1) || (N < M) || ((N % M) != 0)) begin : g_bad_width
        $error("axis_width_conv_narrow_wide: N must be a positive multiple of M");
    end

    localparam int R   = (M > 0) ? (N / M) : 1;
    localparam int K_W = cnt_width(R);

    localparam logic [K_W-1:0]         K_LAST = K_W'(R - 1);
    localparam logic [BIT_COUNT_W-1:0] M_BITS = BIT_COUNT_W'(M);
    localparam logic [BIT_COUNT_W-1:0] N_BITS = BIT_COUNT_W'(N);

    // State registers
    logic [K_W-1:0]         k_q,       k_d;
    logic [N-1:0]           acc_q,     acc_d;
    logic                   gfirst_q,  gfirst_d;
    logic [N-1:0]           m_data_q,  m_data_d;
    logic                   m_first_q, m_first_d;
    logic                   m_valid_q, m_valid_d;
    logic [BIT_COUNT_W-1:0] bcnt_q,    bcnt_d;

    // Handshake decode
    logic out_free_s;
    logic first_stall_s;
    logic s_take_s;
    logic load_s;
    logic flush_s;
    logic m_xfer_s;

    // Handshake: consume unless a new packet must wait for a flush, or the
    // word would complete a group while the output register is still occupied.
    always_comb begin
        out_free_s    = ~m_valid_q | m_axis_tnext;
        m_xfer_s      = m_valid_q & m_axis_tnext;
        first_stall_s = s_axis_tfirst & (k_q != '0);
        s_take_s      = ~rst & s_axis_tvalid & ~first_stall_s
                        & ((k_q < K_LAST) | out_free_s);
        load_s        = s_take_s & (k_q == K_LAST);
        flush_s       = ~rst & s_axis_tvalid & first_stall_s & out_free_s;
    end

    // Next-state for accumulator, group count, output register and occupancy.
    always_comb begin
        k_d       = k_q;
        acc_d     = acc_q;
        gfirst_d  = gfirst_q;
        m_data_d  = m_data_q;
        m_first_d = m_first_q;
        m_valid_d = m_valid_q;

        if (load_s) begin
            // Last slot arrives: the wide word goes straight to the output.
            m_data_d        = acc_q;
            m_data_d[M-1:0] = s_axis_tdata;
            m_first_d       = (k_q == '0) ? s_axis_tfirst : gfirst_q;
            m_valid_d       = 1'b1;
            k_d             = '0;
            gfirst_d        = (k_q == '0) ? s_axis_tfirst : gfirst_q;
        end else if (s_take_s) begin
            // Earlier slot: open a fresh zeroed group at k = 0, then store.
            if (k_q == '0) begin
                acc_d    = '0;
                gfirst_d = s_axis_tfirst;
            end else begin
                gfirst_d = gfirst_q;
            end
            for (int i = 0; i < R; i++) begin
                if (k_q == K_W'(i)) begin
                    acc_d[N-1-i*M -: M] = s_axis_tdata;
                end else begin
                    acc_d[N-1-i*M -: M] = acc_d[N-1-i*M -: M];
                end
            end
            k_d = k_q + K_W'(1);
            if (m_xfer_s) begin
                m_valid_d = 1'b0;
            end else begin
                m_valid_d = m_valid_q;
            end
        end else if (flush_s) begin
            // Unused slots were zeroed when the group opened, giving LSB padding.
            m_data_d  = acc_q;
            m_first_d = gfirst_q;
            m_valid_d = 1'b1;
            k_d       = '0;
        end else if (m_xfer_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        bcnt_d = (BIT_COUNT_W'(k_d) * M_BITS) + (m_valid_d ? N_BITS : '0);
    end

    // State update with synchronous reset; partial groups are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q       <= '0;
            acc_q     <= '0;
            gfirst_q  <= 1'b0;
            m_data_q  <= '0;
            m_first_q <= 1'b0;
            m_valid_q <= 1'b0;
            bcnt_q    <= '0;
        end else begin
            k_q       <= k_d;
            acc_q     <= acc_d;
            gfirst_q  <= gfirst_d;
            m_data_q  <= m_data_d;
            m_first_q <= m_first_d;
            m_valid_q <= m_valid_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign s_axis_tnext  = s_take_s;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tfirst = m_first_q;
    assign m_axis_tvalid = m_valid_q;
    assign bit_count     = bcnt_q;

endmodule

// File: tb/tb_axis_width_conv_narrow_wide.sv
// Directed and randomized checks for the narrow-to-wide converter (N=8, M=4).
module tb_axis_width_conv_narrow_wide;

    localparam int N = 8;
    localparam int M = 4;
    localparam int R = N / M;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_tdata = 4'h0;
    logic        s_tfirst = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tnext;
    logic [7:0]  m_tdata;
    logic        m_tfirst;
    logic        m_tvalid;
    logic        m_tnext;
    logic [15:0] bit_count;

    int   sink_mode = 0;   // 0: tnext = tvalid, 1: tnext = 0, 2: random
    logic sink_rand = 1'b0;

    int tests = 0;
    int fails = 0;

    // Conservation monitor state
    int in_bits = 0, out_words = 0, pad_bits = 0, k_tb = 0, idle_cnt = 0;
    logic chk_en = 1'b0;
    logic [8:0] exp_q[$];

    axis_width_conv_narrow_wide #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tfirst(s_tfirst),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tnext (s_tnext),
        .m_axis_tdata (m_tdata),
        .m_axis_tfirst(m_tfirst),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tnext (m_tnext),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sink_mode == 0)      m_tnext = m_tvalid;
        else if (sink_mode == 1) m_tnext = 1'b0;
        else                     m_tnext = m_tvalid & sink_rand;
    end

    always @(posedge clk) begin
        #1;
        sink_rand = 1'($urandom_range(0, 1));
    end

    // Per-cycle bit conservation, stall watchdog and random-mode scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            in_bits = 0; out_words = 0; pad_bits = 0; k_tb = 0; idle_cnt = 0;
        end else begin
            tests++;
            if (in_bits + pad_bits !== out_words * N + int'(bit_count)) begin
                fails++;
                $display("FAIL conservation: in+pad=%0d required out*N+bit_count=%0d",
                         in_bits + pad_bits, out_words * N + int'(bit_count));
            end
            if (s_tvalid && s_tfirst && k_tb != 0 && (!m_tvalid || m_tnext)) begin
                pad_bits += N - k_tb * M;
                k_tb = 0;
            end
            if (s_tvalid && s_tnext) begin
                in_bits += M;
                k_tb++;
                if (k_tb == R) k_tb = 0;
            end
            if (m_tvalid && m_tnext) begin
                out_words++;
                idle_cnt = 0;
                if (chk_en) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL rnd_extra: got %h/%b, none expected", m_tdata, m_tfirst);
                    end else if ({m_tfirst, m_tdata} !== exp_q[0]) begin
                        fails++;
                        $display("FAIL rnd_data: got first=%b data=%h required first=%b data=%h",
                                 m_tfirst, m_tdata, exp_q[0][8], exp_q[0][7:0]);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end else if (m_tvalid) begin
                idle_cnt++;
                if (idle_cnt == 1000) begin
                    tests++;
                    fails++;
                    $display("FAIL watchdog: no output transfer for %0d cycles", idle_cnt);
                end
            end
        end
    end

    // Drive one input beat after the edge and park at the following negedge.
    task automatic drive(input logic v, input logic [3:0] d, input logic f);
        @(posedge clk); #1;
        s_tvalid = v; s_tdata = d; s_tfirst = f;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = 1'b1; s_tdata = 4'hA; s_tfirst = 1'b1; sink_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (s_tnext !== 1'b0) begin fails++; $display("FAIL rst_tnext: got %b required 0", s_tnext); end
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b required 0", m_tvalid); end
        tests++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL rst_tdata: got %h required 00", m_tdata); end
        tests++; if (m_tfirst !== 1'b0) begin fails++; $display("FAIL rst_tfirst: got %b required 0", m_tfirst); end
        tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL rst_bitcount: got %0d required 0", bit_count); end
        @(posedge clk); #1;
        rst = 1'b0; s_tvalid = 1'b0; s_tfirst = 1'b0;
    endtask

    task automatic test_pack();
        drive(1'b1, 4'hA, 1'b1);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL pack_tnext_a: got %b required 1", s_tnext); end
        drive(1'b1, 4'hB, 1'b0);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL pack_tnext_b: got %b required 1", s_tnext); end
        tests++; if (bit_count !== 16'd4) begin fails++; $display("FAIL pack_bits_4: got %0d required 4", bit_count); end
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL pack_early: got %b required 0", m_tvalid); end
        drive(1'b1, 4'hC, 1'b0);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL pack_tnext_c: got %b required 1", s_tnext); end
        tests++; if ({m_tvalid, m_tfirst, m_tdata} !== {2'b11, 8'hAB}) begin fails++;
            $display("FAIL pack_ab: got v=%b f=%b d=%h required v=1 f=1 d=ab", m_tvalid, m_tfirst, m_tdata); end
        tests++; if (bit_count !== 16'd8) begin fails++; $display("FAIL pack_bits_8: got %0d required 8", bit_count); end
        drive(1'b1, 4'hD, 1'b0);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL pack_tnext_d: got %b required 1", s_tnext); end
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL pack_gap: got %b required 0", m_tvalid); end
        drive(1'b0, 4'h0, 1'b0);
        tests++; if ({m_tvalid, m_tfirst, m_tdata} !== {2'b10, 8'hCD}) begin fails++;
            $display("FAIL pack_cd: got v=%b f=%b d=%h required v=1 f=0 d=cd", m_tvalid, m_tfirst, m_tdata); end
        drive(1'b0, 4'h0, 1'b0);
        tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL pack_drain: got %0d required 0", bit_count); end
    endtask

    task automatic test_first_flush();
        drive(1'b1, 4'h1, 1'b1);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL flush_tnext_1: got %b required 1", s_tnext); end
        drive(1'b1, 4'h2, 1'b1);
        tests++; if (s_tnext !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b required 0", s_tnext); end
        drive(1'b1, 4'h2, 1'b1);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL flush_tnext_2: got %b required 1", s_tnext); end
        tests++; if ({m_tvalid, m_tfirst, m_tdata} !== {2'b11, 8'h10}) begin fails++;
            $display("FAIL flush_10: got v=%b f=%b d=%h required v=1 f=1 d=10", m_tvalid, m_tfirst, m_tdata); end
        drive(1'b1, 4'h3, 1'b0);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL flush_tnext_3: got %b required 1", s_tnext); end
        drive(1'b0, 4'h0, 1'b0);
        tests++; if ({m_tvalid, m_tfirst, m_tdata} !== {2'b11, 8'h23}) begin fails++;
            $display("FAIL flush_23: got v=%b f=%b d=%h required v=1 f=1 d=23", m_tvalid, m_tfirst, m_tdata); end
        drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_backpressure();
        sink_mode = 1;
        drive(1'b1, 4'h5, 1'b1);
        drive(1'b1, 4'h6, 1'b0);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL bp_tnext_6: got %b required 1", s_tnext); end
        drive(1'b1, 4'h7, 1'b0);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL bp_tnext_7: got %b required 1", s_tnext); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h8, 1'b0);
            tests++; if (s_tnext !== 1'b0) begin fails++; $display("FAIL bp_hold_tnext[%0d]: got %b required 0", i, s_tnext); end
            tests++; if ({m_tvalid, m_tdata} !== {1'b1, 8'h56}) begin fails++;
                $display("FAIL bp_hold_data[%0d]: got v=%b d=%h required v=1 d=56", i, m_tvalid, m_tdata); end
            tests++; if (bit_count !== 16'd12) begin fails++; $display("FAIL bp_bits[%0d]: got %0d required 12", i, bit_count); end
        end
        @(posedge clk); #1;
        sink_mode = 0;
        @(negedge clk);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL bp_release: got %b required 1", s_tnext); end
        drive(1'b0, 4'h0, 1'b0);
        tests++; if ({m_tvalid, m_tfirst, m_tdata} !== {2'b10, 8'h78}) begin fails++;
            $display("FAIL bp_78: got v=%b f=%b d=%h required v=1 f=0 d=78", m_tvalid, m_tfirst, m_tdata); end
        drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'h9, 1'b1);
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL rmid_tnext_9: got %b required 1", s_tnext); end
        @(posedge clk); #1;
        rst = 1'b1; s_tvalid = 1'b1; s_tdata = 4'hE; s_tfirst = 1'b1;
        @(negedge clk);
        tests++; if (s_tnext !== 1'b0) begin fails++; $display("FAIL rmid_tnext_rst: got %b required 0", s_tnext); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL rmid_bits: got %0d required 0", bit_count); end
        tests++; if (s_tnext !== 1'b1) begin fails++; $display("FAIL rmid_tnext_e: got %b required 1", s_tnext); end
        drive(1'b1, 4'hF, 1'b0);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rmid_leak: got v=%b d=%h required v=0", m_tvalid, m_tdata); end
        drive(1'b0, 4'h0, 1'b0);
        tests++; if ({m_tvalid, m_tfirst, m_tdata} !== {2'b11, 8'hEF}) begin fails++;
            $display("FAIL rmid_ef: got v=%b f=%b d=%h required v=1 f=1 d=ef", m_tvalid, m_tfirst, m_tdata); end
        drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] wd[1024];
        logic       wf[1024];
        logic [7:0] acc;
        logic       gf;
        int         k;
        int         cnt;
        logic       stuck;

        k = 0; acc = 8'h00; gf = 1'b0; stuck = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            wd[i] = 4'($urandom_range(0, 15));
            wf[i] = (i == 0) ? 1'b1 : ($urandom_range(0, 11) == 0);
            if (wf[i] && k != 0) begin
                exp_q.push_back({gf, acc});
                k = 0;
            end
            if (k == 0) begin
                acc = 8'h00;
                gf  = wf[i];
            end
            if (k == 0) acc[7:4] = wd[i];
            else        acc[3:0] = wd[i];
            k++;
            if (k == R) begin
                exp_q.push_back({gf, acc});
                k = 0;
            end
        end

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; chk_en = 1'b1; sink_mode = 2;

        for (int i = 0; i < 1024 && !stuck; i++) begin
            @(posedge clk); #1;
            s_tvalid = 1'b1; s_tdata = wd[i]; s_tfirst = wf[i];
            @(negedge clk);
            cnt = 0;
            while (!s_tnext && cnt < 1000) begin
                @(negedge clk);
                cnt++;
            end
            if (!s_tnext) begin
                tests++; fails++; stuck = 1'b1;
                $display("FAIL rnd_input_timeout: word %0d not consumed within %0d cycles", i, cnt);
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tfirst = 1'b0;

        cnt = 0;
        while ((exp_q.size() != 0 || m_tvalid) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        tests++; if (exp_q.size() != 0) begin fails++;
            $display("FAIL rnd_drain: got %0d outputs outstanding required 0", exp_q.size()); end
        @(negedge clk);
        tests++; if (int'(bit_count) !== k * M) begin fails++;
            $display("FAIL rnd_leftover: got bit_count=%0d required %0d", bit_count, k * M); end
        chk_en = 1'b0;
        sink_mode = 0;
    endtask

    initial begin
        test_reset();
        test_pack();
        test_first_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
